// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared types and constants for the gate BIST controller.
//   state_e     - controller states (IDLE, SETTLE, CHECK, DONE)
//   NUM_VEC     - number of {A,B} input vectors of a 2-input gate
//   VEC_W       - width of the vector register
//   FC_W        - width of the mismatch counter (holds 0..NUM_VEC)
//   TT_*        - expected truth tables, bit index = {A,B}
package gate_bist_pkg;

  localparam int NUM_VEC = 4;
  localparam int VEC_W   = 2;
  localparam int FC_W    = 3;

  localparam logic [NUM_VEC-1:0] TT_AND  = 4'b1000;
  localparam logic [NUM_VEC-1:0] TT_OR   = 4'b1110;
  localparam logic [NUM_VEC-1:0] TT_XOR  = 4'b0110;
  localparam logic [NUM_VEC-1:0] TT_NAND = 4'b0111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage : gate_bist_pkg

// File: rtl/gate_bist_settle_timer.sv
// gate_bist_settle_timer: settle-time counter for the gate BIST controller.
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - clear the counter to 0 (has priority over count)
//   count      - increment the counter by one
//   expire     - counter has reached SETTLE_CYCLES-1
// Parameters: SETTLE_CYCLES (1..255), CNT_W (must hold SETTLE_CYCLES-1).
module gate_bist_settle_timer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expire
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 ||
      (SETTLE_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_param
    $error("gate_bist_settle_timer: SETTLE_CYCLES must be 1..255 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples values from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (cnt == LAST);

endmodule : gate_bist_settle_timer

// File: rtl/gate_bist.sv
// gate_bist: built-in self-test controller for a 2-input combinational gate.
// Walks {A,B} through 00,01,10,11, holds each vector SETTLE_CYCLES cycles,
// then compares the gate response against TRUTH_TABLE for one CHECK cycle.
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - begin a run (honoured only in IDLE or DONE)
//   abort       - (only with GATE_BIST_ABORT_EN) cancel a run in progress
//   gate_f      - response of the gate under test
//   gate_a/b    - stimulus to the gate under test
//   busy        - run in progress
//   done        - run complete; held until next start or reset
//   pass        - valid with done: no vector mismatched
//   fail_count  - number of mismatching vectors
//   fail_mask   - bit i set if vector {A,B}=i mismatched
// Optional feature macro: GATE_BIST_ABORT_EN adds the abort input.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] TRUTH_TABLE   = TT_AND,
  parameter int                 SETTLE_CYCLES = 4,
  parameter int                 CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef GATE_BIST_ABORT_EN
  input  logic               abort,
`endif
  input  logic               gate_f,
  output logic               gate_a,
  output logic               gate_b,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [FC_W-1:0]    fail_count,
  output logic [NUM_VEC-1:0] fail_mask
);

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

  state_e            state;
  logic [VEC_W-1:0]  vec;
  logic              timer_load;
  logic              timer_count;
  logic              timer_expire;
  logic              start_ok;
  logic              abort_hit;
  logic              mismatch;
  logic [FC_W-1:0]   count_next;

  assign start_ok = start && (state == IDLE || state == DONE);

`ifdef GATE_BIST_ABORT_EN
  assign abort_hit = abort && (state == SETTLE || state == CHECK);
`else
  assign abort_hit = 1'b0;
`endif

  assign mismatch   = (gate_f != TRUTH_TABLE[vec]);
  assign count_next = fail_count + FC_W'(mismatch);

  // Counter restarts on a new run and on each advance to the next vector;
  // it stops at its last value so SETTLE lasts exactly SETTLE_CYCLES cycles.
  assign timer_load  = start_ok || (state == CHECK && vec != LAST_VEC && !abort_hit);
  assign timer_count = (state == SETTLE) && !timer_expire && !abort_hit;

  gate_bist_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .count  (timer_count),
    .expire (timer_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= '0;
      fail_mask  <= '0;
    end else if (abort_hit) begin
      state      <= IDLE;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= '0;
      fail_mask  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= SETTLE;
            vec        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_count <= '0;
            fail_mask  <= '0;
          end
        end
        SETTLE: begin
          if (timer_expire) state <= CHECK;
        end
        CHECK: begin
          if (mismatch) fail_mask[vec] <= 1'b1;
          fail_count <= count_next;
          if (vec == LAST_VEC) begin
            // Stimulus stays at 1/1 while results are held in DONE.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (count_next == '0);
          end else begin
            vec   <= vec + 1'b1;
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gate_a = vec[1];
  assign gate_b = vec[0];

endmodule : gate_bist

// File: tb/tb_gate_bist.sv
// tb_gate_bist: self-checking bench for gate_bist. A behavioural gate model
// (correct AND, OR, stuck-at-1, XOR) drives gate_f; expected results are
// pushed to a scoreboard queue when a run starts and popped when done rises.
module tb_gate_bist;
  import gate_bist_pkg::*;

  localparam int SETTLE  = 4;
  localparam int VEC_CYC = SETTLE + 1;
  localparam int RUN_LAT = 4 * VEC_CYC;

  typedef enum int {G_AND, G_OR, G_STUCK1, G_XOR} gate_mode_e;

  typedef struct {
    logic       pass;
    logic [2:0] count;
    logic [3:0] mask;
  } result_t;

  result_t    sb_q[$];
  gate_mode_e mode;

  logic       clk;
  logic       rst_n;
  logic       start;
`ifdef GATE_BIST_ABORT_EN
  logic       abort;
`endif
  logic       gate_f;
  logic       gate_a;
  logic       gate_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] fail_count;
  logic [3:0] fail_mask;

  int n_checks = 0;
  int n_pass   = 0;

  gate_bist #(
    .TRUTH_TABLE   (TT_AND),
    .SETTLE_CYCLES (SETTLE),
    .CNT_W         (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
`ifdef GATE_BIST_ABORT_EN
    .abort      (abort),
`endif
    .gate_f     (gate_f),
    .gate_a     (gate_a),
    .gate_b     (gate_b),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_count (fail_count),
    .fail_mask  (fail_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic gate_model(input gate_mode_e m, input logic a, input logic b);
    case (m)
      G_AND:    return a & b;
      G_OR:     return a | b;
      G_STUCK1: return 1'b1;
      default:  return a ^ b;
    endcase
  endfunction

  always_comb gate_f = gate_model(mode, gate_a, gate_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic result_t expected_result(input gate_mode_e m);
    result_t    r;
    logic [3:0] tt;
    logic [1:0] v;
    tt = TT_AND;
    r.count = '0;
    r.mask  = '0;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      if (gate_model(m, v[1], v[0]) != tt[i]) begin
        r.mask[i] = 1'b1;
        r.count   = r.count + 3'd1;
      end
    end
    r.pass = (r.count == 3'd0);
    return r;
  endfunction

  // All twelve output bits, for checking reset/abort clears at once.
  function automatic logic [11:0] all_outs();
    return {gate_a, gate_b, busy, done, pass, fail_count, fail_mask};
  endfunction

  // Pulse start, follow the vector sequence, score the result when done rises.
  task automatic run_and_check(input gate_mode_e m, input bit extra_start);
    result_t exp;
    bit      seen;
    mode = m;
    sb_q.push_back(expected_result(m));
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < RUN_LAT + 10 && !seen; k++) begin
      if (k == 0) begin
        check("start_clears_done", done, 1'b0);
        check("start_clears_count", fail_count, 3'd0);
        check("start_clears_mask", fail_mask, 4'd0);
        check("start_sets_busy", busy, 1'b1);
      end
      if (done) begin
        seen = 1'b1;
        exp  = sb_q.pop_front();
        check("done_latency", k, RUN_LAT);
        check("pass", pass, exp.pass);
        check("fail_count", fail_count, exp.count);
        check("fail_mask", fail_mask, exp.mask);
        check("busy_after_done", busy, 1'b0);
        check("ab_in_done", {gate_a, gate_b}, 2'b11);
      end else if (k < RUN_LAT) begin
        check("vec_seq", {gate_a, gate_b}, k / VEC_CYC);
      end
      if (extra_start) start = (k == 11);
      if (!seen) @(negedge clk);
    end
    start = 1'b0;
    if (!seen) begin
      check("done_timeout", 1'b0, 1'b1);
      exp = sb_q.pop_front();
    end
    repeat (3) @(negedge clk);
    check("done_held", done, 1'b1);
    check("mask_held", fail_mask, exp.mask);
  endtask

  task automatic reset_mid_run();
    mode = G_AND;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (6) @(negedge clk);
    check("vec1_before_reset", {gate_a, gate_b}, 2'b01);
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", all_outs(), 12'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", all_outs(), 12'd0);
  endtask

`ifdef GATE_BIST_ABORT_EN
  task automatic abort_in_check();
    mode = G_XOR;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (RUN_LAT - 1) @(negedge clk);
    check("vec3_before_abort", {gate_a, gate_b}, 2'b11);
    check("busy_before_abort", busy, 1'b1);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check("abort_outs", all_outs(), 12'd0);
    repeat (3) @(negedge clk);
    check("idle_after_abort", all_outs(), 12'd0);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = G_AND;
`ifdef GATE_BIST_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_outs", all_outs(), 12'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_start", all_outs(), 12'd0);

    run_and_check(G_AND, 1'b0);
    run_and_check(G_OR, 1'b0);
    run_and_check(G_STUCK1, 1'b0);
    run_and_check(G_AND, 1'b1);
    reset_mid_run();
    run_and_check(G_STUCK1, 1'b0);
`ifdef GATE_BIST_ABORT_EN
    abort_in_check();
    run_and_check(G_AND, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_gate_bist
